// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the streaming bubble sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } sort_state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DATA_N = 8;

  // The shared counter must hold 0..DATA_N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cswap.sv
// Combinational compare-swap: o_lo/o_hi are the pair in output order for one network slot.
module sort_cswap #(
  parameter int DATA_W  = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_hi
);

  logic w_swap;

  // Strict compares so equal words stay in place.
  assign w_swap = DESCEND ? (i_a < i_b) : (i_a > i_b);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

endmodule

// File: rtl/stream_bubble_sorter.sv
// Streaming sorter: loads DATA_N words, runs DATA_N odd-even transposition passes,
// then drains the sorted frame one word per handshake with a last flag.
module stream_bubble_sorter
  import sort_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DATA_N  = DEF_DATA_N,
  parameter bit DESCEND = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_N - 1);

  sort_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_rd_idx;
  logic [DATA_W-1:0] r_buf     [DATA_N];
  logic [DATA_W-1:0] w_buf_nxt [DATA_N];
  logic [DATA_W-1:0] w_lo      [DATA_N-1];
  logic [DATA_W-1:0] w_hi      [DATA_N-1];
  logic [DATA_N-2:0] w_pair_en;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt, w_rd_data;
  logic              r_in_ready, r_out_valid, r_out_last, r_busy;
  logic              w_out_valid_nxt, w_out_last_nxt;
  logic              w_in_fire, w_out_fire;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Pass parity (low counter bit) selects the even or odd pairs.
  for (genvar k = 0; k < DATA_N - 1; k++) begin : g_pair
    sort_cswap #(.DATA_W(DATA_W), .DESCEND(DESCEND)) u_cswap (
      .i_a (r_buf[k]),
      .i_b (r_buf[k+1]),
      .o_lo(w_lo[k]),
      .o_hi(w_hi[k])
    );
    assign w_pair_en[k] = (r_state == S_SORT) && (r_cnt[0] == 1'(k % 2));
  end

  always_comb begin
    w_buf_nxt = r_buf;
    if (r_state == S_LOAD && w_in_fire) begin
      for (int j = 0; j < DATA_N; j++) begin
        if (r_cnt == CNT_W'(j)) begin
          w_buf_nxt[j] = in_data;
        end else begin
          w_buf_nxt[j] = r_buf[j];
        end
      end
    end else begin
      for (int k = 0; k < DATA_N - 1; k++) begin
        if (w_pair_en[k]) begin
          w_buf_nxt[k]   = w_lo[k];
          w_buf_nxt[k+1] = w_hi[k];
        end
      end
    end
  end

  // Next drained word: slot 0 when priming, otherwise the slot after the current one.
  always_comb begin
    w_rd_idx  = r_out_valid ? (r_cnt + CNT_W'(1)) : CNT_W'(0);
    w_rd_data = r_buf[0];
    for (int j = 0; j < DATA_N; j++) begin
      if (w_rd_idx == CNT_W'(j)) begin
        w_rd_data = r_buf[j];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      S_LOAD: begin
        if (w_in_fire) begin
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = S_SORT;
            w_cnt_nxt   = CNT_W'(0);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_SORT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = CNT_W'(0);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle registers word 0 before out_valid rises.
        if (!r_out_valid) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_rd_data;
          w_out_last_nxt  = 1'b0;
        end else if (w_out_fire) begin
          if (r_out_last) begin
            w_state_nxt     = S_LOAD;
            w_cnt_nxt       = CNT_W'(0);
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = {DATA_W{1'b0}};
            w_out_last_nxt  = 1'b0;
          end else begin
            w_cnt_nxt      = r_cnt + CNT_W'(1);
            w_out_data_nxt = w_rd_data;
            w_out_last_nxt = ((r_cnt + CNT_W'(1)) == LAST_IDX);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt     = S_LOAD;
        w_cnt_nxt       = CNT_W'(0);
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = {DATA_W{1'b0}};
        w_out_last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_cnt       <= CNT_W'(0);
      for (int j = 0; j < DATA_N; j++) begin
        r_buf[j] <= {DATA_W{1'b0}};
      end
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= (w_state_nxt != S_LOAD);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_stream_bubble_sorter.sv
// Self-checking bench: directed and random frames against a queue-sort reference model.
module tb_stream_bubble_sorter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [3:0] a_in_data, a_out_data;
  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last, d_busy;
  logic [3:0] d_in_data, d_out_data;

  stream_bubble_sorter #(.DATA_W(4), .DATA_N(8), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  stream_bubble_sorter #(.DATA_W(4), .DATA_N(8), .DESCEND(1'b1)) u_dsc (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_last(d_out_last), .busy(d_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t_first = 0;
  int t_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_sort(input logic [3:0] w[8], input bit dsc, output logic [3:0] e[8]);
    int q[$];
    for (int i = 0; i < 8; i++) q.push_back(int'(w[i]));
    if (dsc) q.rsort();
    else q.sort();
    for (int i = 0; i < 8; i++) e[i] = 4'(q[i]);
  endfunction

  task automatic peek(input bit dsc, output logic ov, output logic [3:0] od, output logic ol,
                      output logic ir, output logic bs);
    ov = dsc ? d_out_valid : a_out_valid;
    od = dsc ? d_out_data  : a_out_data;
    ol = dsc ? d_out_last  : a_out_last;
    ir = dsc ? d_in_ready  : a_in_ready;
    bs = dsc ? d_busy      : a_busy;
  endtask

  task automatic load_frame(input bit dsc, input logic [3:0] w[8], input bit gaps);
    int k, guard;
    bit v;
    logic rdy;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 300) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (dsc) begin d_in_valid = v; d_in_data = w[k]; rdy = d_in_ready; end
      else     begin a_in_valid = v; a_in_data = w[k]; rdy = a_in_ready; end
      chk("in_ready_load", rdy, 1);
      @(posedge clk); #1;
      if (v && rdy) begin
        if (k == 0) t_first = cyc;
        k++;
      end
      guard++;
    end
    a_in_valid = 1'b0;
    d_in_valid = 1'b0;
    t_last = cyc;
    chk("load_count", k, 8);
  endtask

  // mode 0: always ready, 1: toggled 1010..., 2: random
  task automatic drain_frame(input bit dsc, input logic [3:0] w[8], input int mode, input bit chk_lat);
    logic [3:0] e[8];
    logic [3:0] od;
    logic ov, ol, ir, bs;
    bit ordy;
    int k, guard, ph;
    ref_sort(w, dsc, e);
    guard = 0;
    peek(dsc, ov, od, ol, ir, bs);
    while (!ov && guard < 60) begin
      chk("in_ready_sort", ir, 0);
      chk("busy_sort", bs, 1);
      @(posedge clk); #1;
      guard++;
      peek(dsc, ov, od, ol, ir, bs);
    end
    chk("valid_timeout", ov, 1);
    if (chk_lat) chk("latency", cyc - t_last, 9);
    k = 0;
    ph = 0;
    while (k < 8 && guard < 400) begin
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = (ph % 2 == 0);
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      if (dsc) d_out_ready = ordy;
      else     a_out_ready = ordy;
      peek(dsc, ov, od, ol, ir, bs);
      chk("drain_valid", ov, 1);
      chk("drain_data", od, e[k]);
      chk("drain_last", ol, (k == 7));
      chk("in_ready_drain", ir, 0);
      chk("busy_drain", bs, 1);
      @(posedge clk); #1;
      ph++;
      guard++;
      if (ov && ordy) k++;
    end
    a_out_ready = 1'b0;
    d_out_ready = 1'b0;
    chk("drain_count", k, 8);
    peek(dsc, ov, od, ol, ir, bs);
    chk("busy_after_last", bs, 0);
    chk("in_ready_after_last", ir, 1);
    chk("valid_after_last", ov, 0);
  endtask

  initial begin
    logic [3:0] f[8];
    logic [3:0] od;
    logic ov, ol, ir, bs;
    int prev_first;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 4'h0; a_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_data = 4'h0; d_out_ready = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      peek(s[0], ov, od, ol, ir, bs);
      chk("rst_in_ready", ir, 1);
      chk("rst_out_valid", ov, 0);
      chk("rst_out_data", od, 0);
      chk("rst_out_last", ol, 0);
      chk("rst_busy", bs, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    f = '{4'h5, 4'h3, 4'hF, 4'h0, 4'h7, 4'h7, 4'h1, 4'h9};
    load_frame(1'b0, f, 1'b0);
    drain_frame(1'b0, f, 0, 1'b1);

    f = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    load_frame(1'b0, f, 1'b0);
    drain_frame(1'b0, f, 0, 1'b1);

    f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    load_frame(1'b0, f, 1'b0);
    drain_frame(1'b0, f, 0, 1'b1);

    for (int i = 0; i < 8; i++) f[i] = 4'($urandom_range(0, 15));
    load_frame(1'b0, f, 1'b1);
    drain_frame(1'b0, f, 1, 1'b1);

    f = '{4'h2, 4'h2, 4'h0, 4'hF, 4'h1, 4'h1, 4'h8, 4'h3};
    load_frame(1'b1, f, 1'b0);
    drain_frame(1'b1, f, 0, 1'b1);

    // Abort a frame during pass 3, then check the next frame is clean.
    for (int i = 0; i < 8; i++) f[i] = 4'($urandom_range(0, 15));
    load_frame(1'b0, f, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", a_busy, 1);
    rst = 1'b1;
    #1;
    peek(1'b0, ov, od, ol, ir, bs);
    chk("abort_out_valid", ov, 0);
    chk("abort_out_data", od, 0);
    chk("abort_in_ready", ir, 1);
    chk("abort_busy", bs, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    f = '{4'h4, 4'h8, 4'h1, 4'h6, 4'h3, 4'h7, 4'h2, 4'h5};
    load_frame(1'b0, f, 1'b0);
    drain_frame(1'b0, f, 0, 1'b1);

    prev_first = 0;
    for (int fr = 0; fr < 8; fr++) begin
      for (int i = 0; i < 8; i++) f[i] = 4'($urandom_range(0, 15));
      load_frame(1'b0, f, 1'b0);
      if (fr > 0) chk("frame_period", t_first - prev_first, 25);
      prev_first = t_first;
      drain_frame(1'b0, f, 0, 1'b1);
    end

    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 8; i++) f[i] = 4'($urandom_range(0, 15));
      load_frame(1'b0, f, 1'b1);
      drain_frame(1'b0, f, 2, 1'b1);
      load_frame(1'b1, f, 1'b1);
      drain_frame(1'b1, f, 2, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
